// File: rtl/ahb_to_ssram_pw_if.sv
// rtl/ahb_to_ssram_pw_if.sv - AHB-Lite slave port plus SRAM macro port of the SSRAM bridge
interface ahb_to_ssram_pw_if #(
    parameter int AW = 14,
    parameter int DW = 32
);
    localparam int NB = DW / 8;
    localparam int BL = $clog2(NB);

    logic             HSEL;
    logic [AW-1:0]    HADDR;
    logic [1:0]       HTRANS;
    logic [2:0]       HSIZE;
    logic             HWRITE;
    logic [DW-1:0]    HWDATA;
    logic             HREADY;
    logic             HREADYOUT;
    logic [DW-1:0]    HRDATA;
    logic             HRESP;

    logic [AW-BL-1:0] ahb_sram_addr;
    logic             ahb_sram_en;
    logic             ahb_sram_we;
    logic [NB-1:0]    ahb_sram_wb;
    logic [DW-1:0]    ahb_sram_din;
    logic [DW-1:0]    sram_ahb_dout;

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY, sram_ahb_dout,
        output HREADYOUT, HRDATA, HRESP,
        output ahb_sram_addr, ahb_sram_en, ahb_sram_we, ahb_sram_wb, ahb_sram_din
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY, sram_ahb_dout,
        input  HREADYOUT, HRDATA, HRESP,
        input  ahb_sram_addr, ahb_sram_en, ahb_sram_we, ahb_sram_wb, ahb_sram_din
    );
endinterface

// File: rtl/ahb_to_ssram_pw.sv
// rtl/ahb_to_ssram_pw.sv - AHB-Lite to sync SRAM bridge with posted-write buffer and read forwarding
// Optional ERROR response on oversize/misaligned transfers: define AHB_SSRAM_PW_ERR_EN
module ahb_to_ssram_pw #(
    parameter int AW     = 14,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    ahb_to_ssram_pw_if.slave bus
);
    localparam int NB = DW / 8;
    localparam int BL = $clog2(NB);
    localparam int WA = AW - BL;

    typedef enum logic [1:0] {ST_IDLE, ST_RD_WAIT, ST_ERR} state_t;

    state_t        state;
    logic          hreadyout_q;
    logic          hresp_q;
    logic          dp_read;
    logic          dp_write;
    logic [WA-1:0] dp_addr;
    logic [NB-1:0] dp_mask;
    logic          wbuf_valid;
    logic [WA-1:0] wbuf_addr;
    logic [NB-1:0] wbuf_mask;
    logic [DW-1:0] wbuf_data;
    logic          fwd_hit;
    logic [NB-1:0] fwd_mask;
    logic [DW-1:0] fwd_data;
    logic [DW-1:0] fwd_bits;

    logic          accept;
    logic          err_req;
    logic          rd_issue;
    logic          wr_accept;
    logic          wr_direct;
    logic          wr_post;
    logic          drain;
    logic [WA-1:0] rd_waddr;
    logic          src_valid;
    logic [WA-1:0] src_addr;
    logic [NB-1:0] src_mask;
    logic [DW-1:0] src_data;

    // Byte i is enabled when it falls in the same naturally aligned chunk as the address.
    function automatic logic [NB-1:0] lane_mask(input logic [2:0] size, input logic [BL-1:0] lo);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++)
            m[i] = ((i >> size) == (int'(lo) >> size));
        return m;
    endfunction

    assign accept = bus.HSEL && bus.HREADY && (bus.HTRANS == 2'b10 || bus.HTRANS == 2'b11);

`ifdef AHB_SSRAM_PW_ERR_EN
    assign err_req = accept && ((int'(bus.HSIZE) > BL) ||
                     ((int'(bus.HADDR[BL-1:0]) & ((1 << bus.HSIZE) - 1)) != 0));
`else
    assign err_req = 1'b0;
`endif

    assign rd_issue  = accept && !bus.HWRITE && !err_req;
    assign wr_accept = accept && bus.HWRITE && !err_req;
    assign wr_direct = dp_write && bus.HREADY && !rd_issue;
    assign wr_post   = dp_write && rd_issue;
    assign drain     = wbuf_valid && bus.HREADY && !rd_issue && !dp_write && !err_req;
    assign rd_waddr  = bus.HADDR[AW-1:BL];

    // Write data arriving alongside this read is about to enter the buffer, so forward from it.
    assign src_valid = dp_write || wbuf_valid;
    assign src_addr  = dp_write ? dp_addr    : wbuf_addr;
    assign src_mask  = dp_write ? dp_mask    : wbuf_mask;
    assign src_data  = dp_write ? bus.HWDATA : wbuf_data;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            dp_read     <= 1'b0;
            dp_write    <= 1'b0;
            dp_addr     <= '0;
            dp_mask     <= '0;
            wbuf_valid  <= 1'b0;
            wbuf_addr   <= '0;
            wbuf_mask   <= '0;
            wbuf_data   <= '0;
            fwd_hit     <= 1'b0;
            fwd_mask    <= '0;
            fwd_data    <= '0;
        end else begin
            if (wr_post) begin
                wbuf_valid <= 1'b1;
                wbuf_addr  <= dp_addr;
                wbuf_mask  <= dp_mask;
                wbuf_data  <= bus.HWDATA;
            end else if (drain) begin
                wbuf_valid <= 1'b0;
            end

            if (bus.HREADY) begin
                dp_read  <= rd_issue;
                dp_write <= wr_accept;
                if (accept) begin
                    dp_addr <= rd_waddr;
                    dp_mask <= lane_mask(bus.HSIZE, bus.HADDR[BL-1:0]);
                end
                fwd_hit  <= rd_issue && src_valid && (src_addr == rd_waddr);
                fwd_mask <= src_mask;
                fwd_data <= src_data;
            end

            case (state)
                ST_RD_WAIT: begin
                    hreadyout_q <= 1'b1;
                    state       <= ST_IDLE;
                end
                ST_ERR: begin
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    if (bus.HREADY) begin
                        if (err_req) begin
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 1'b1;
                            state       <= ST_ERR;
                        end else if (rd_issue && RD_LAT == 2) begin
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 1'b0;
                            state       <= ST_RD_WAIT;
                        end else begin
                            hreadyout_q <= 1'b1;
                            hresp_q     <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        fwd_bits = '0;
        for (int i = 0; i < NB; i++)
            fwd_bits[8*i +: 8] = {8{fwd_hit & fwd_mask[i]}};
    end

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = dp_read ? ((bus.sram_ahb_dout & ~fwd_bits) | (fwd_data & fwd_bits)) : '0;

    // Strobes are gated by reset so they drop the moment reset asserts.
    assign bus.ahb_sram_en   = HRESETn && (rd_issue || wr_direct || drain);
    assign bus.ahb_sram_we   = HRESETn && (wr_direct || drain);
    assign bus.ahb_sram_addr = rd_issue ? rd_waddr : (wr_direct ? dp_addr : wbuf_addr);
    assign bus.ahb_sram_wb   = !HRESETn ? '0 : (wr_direct ? dp_mask : (drain ? wbuf_mask : '0));
    assign bus.ahb_sram_din  = wr_direct ? bus.HWDATA : wbuf_data;
endmodule
